// File: rtl/regfile_rename_pkg.sv
// Shared widths and constants for the renaming register file.
// Tag value zero doubles as "no producer, value ready".
package regfile_rename_pkg;
  localparam int RegNum      = 32;
  localparam int RegIdxWidth = 5;
  localparam int ROBIdxWidth = 4;
  localparam int WordWidth   = 32;

  typedef logic [WordWidth-1:0]   word_t;
  typedef logic [ROBIdxWidth-1:0] tag_t;
  typedef logic [RegIdxWidth-1:0] idx_t;

  localparam word_t ZERO   = '0;
  localparam tag_t  NO_TAG = '0;
endpackage

// File: rtl/regfile_rename_read_port.sv
// One operand read port: x0 rule, storage lookup, and
// same-cycle commit bypass when the committing slot owns the tag.
module regfile_read_port
  import regfile_rename_pkg::*;
(
  input  logic [RegIdxWidth-1:0] idx_i,
  input  logic [WordWidth-1:0]   val_i [1:RegNum-1],
  input  logic [ROBIdxWidth-1:0] tag_i [1:RegNum-1],
  input  logic                   commit_en_i,
  input  logic [RegIdxWidth-1:0] commit_rd_i,
  input  logic [ROBIdxWidth-1:0] commit_pos_i,
  input  logic [WordWidth-1:0]   commit_res_i,
  output logic [WordWidth-1:0]   val_o,
  output logic [ROBIdxWidth-1:0] tag_o
);

  logic hit;

  always_comb begin
    val_o = ZERO;
    tag_o = NO_TAG;
    hit   = 1'b0;
    if (idx_i != '0) begin
      hit = commit_en_i
         && (commit_rd_i == idx_i)
         && (tag_i[idx_i] == commit_pos_i);
      if (hit) begin
        val_o = commit_res_i;
      end else begin
        val_o = val_i[idx_i];
        tag_o = tag_i[idx_i];
      end
    end
  end

endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with rename tags: issue renames,
// commit retires and releases, branch flush drops all tags.
module regfile_rename
  import regfile_rename_pkg::*;
(
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   rdy_in,
  input  logic [RegIdxWidth-1:0] rs1_idx_in,
  input  logic [RegIdxWidth-1:0] rs2_idx_in,
  output logic [WordWidth-1:0]   rs1_val_out,
  output logic [ROBIdxWidth-1:0] rs1_tag_out,
  output logic [WordWidth-1:0]   rs2_val_out,
  output logic [ROBIdxWidth-1:0] rs2_tag_out,
  input  logic                   issue_en_in,
  input  logic [RegIdxWidth-1:0] issue_rd_in,
  input  logic [ROBIdxWidth-1:0] issue_rob_pos_in,
  input  logic                   commit_en_in,
  input  logic [RegIdxWidth-1:0] commit_rd_in,
  input  logic [ROBIdxWidth-1:0] commit_rob_pos_in,
  input  logic [WordWidth-1:0]   commit_res_in,
  input  logic                   clear_branch_in
);

  logic [WordWidth-1:0]   val_q [1:RegNum-1];
  logic [WordWidth-1:0]   val_d [1:RegNum-1];
  logic [ROBIdxWidth-1:0] tag_q [1:RegNum-1];
  logic [ROBIdxWidth-1:0] tag_d [1:RegNum-1];

  // Release compares the pre-edge tag, so a younger rename survives;
  // issue (or flush) then overrides the released tag.
  always_comb begin
    for (int i = 1; i < RegNum; i++) begin
      val_d[i] = val_q[i];
      tag_d[i] = tag_q[i];
      if (rdy_in) begin
        if (commit_en_in
            && commit_rd_in == RegIdxWidth'(i)) begin
          val_d[i] = commit_res_in;
          if (tag_q[i] == commit_rob_pos_in) begin
            tag_d[i] = NO_TAG;
          end
        end
        if (clear_branch_in) begin
          tag_d[i] = NO_TAG;
        end else if (issue_en_in
            && issue_rd_in == RegIdxWidth'(i)) begin
          tag_d[i] = issue_rob_pos_in;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 1; i < RegNum; i++) begin
        val_q[i] <= ZERO;
        tag_q[i] <= NO_TAG;
      end
    end else begin
      for (int i = 1; i < RegNum; i++) begin
        val_q[i] <= val_d[i];
        tag_q[i] <= tag_d[i];
      end
    end
  end

  regfile_read_port u_rs1 (
    .idx_i        (rs1_idx_in),
    .val_i        (val_q),
    .tag_i        (tag_q),
    .commit_en_i  (commit_en_in),
    .commit_rd_i  (commit_rd_in),
    .commit_pos_i (commit_rob_pos_in),
    .commit_res_i (commit_res_in),
    .val_o        (rs1_val_out),
    .tag_o        (rs1_tag_out)
  );

  regfile_read_port u_rs2 (
    .idx_i        (rs2_idx_in),
    .val_i        (val_q),
    .tag_i        (tag_q),
    .commit_en_i  (commit_en_in),
    .commit_rd_i  (commit_rd_in),
    .commit_pos_i (commit_rob_pos_in),
    .commit_res_i (commit_res_in),
    .val_o        (rs2_val_out),
    .tag_o        (rs2_tag_out)
  );

endmodule

// File: tb/tb_regfile_rename.sv
// Self-checking bench for regfile_rename: directed scenarios plus
// randomized traffic against an array-based reference model.
module tb_regfile_rename;

  logic        clk = 1'b0;
  logic        rst_n, rdy, ien, cen, flush;
  logic [4:0]  rs1, rs2, ird, crd;
  logic [3:0]  ipos, cpos;
  logic [31:0] cres;
  logic [31:0] rs1_val, rs2_val;
  logic [3:0]  rs1_tag, rs2_tag;

  int total = 0;
  int bad   = 0;

  logic [31:0] mv [32];
  logic [3:0]  mt [32];

  always #5 clk = ~clk;

  regfile_rename dut (
    .clk_in            (clk),
    .rst_n_in          (rst_n),
    .rdy_in            (rdy),
    .rs1_idx_in        (rs1),
    .rs2_idx_in        (rs2),
    .rs1_val_out       (rs1_val),
    .rs1_tag_out       (rs1_tag),
    .rs2_val_out       (rs2_val),
    .rs2_tag_out       (rs2_tag),
    .issue_en_in       (ien),
    .issue_rd_in       (ird),
    .issue_rob_pos_in  (ipos),
    .commit_en_in      (cen),
    .commit_rd_in      (crd),
    .commit_rob_pos_in (cpos),
    .commit_res_in     (cres),
    .clear_branch_in   (flush)
  );

  function automatic logic [35:0] exp_rd(input logic [4:0] idx);
    if (idx == 5'd0) return 36'h0;
    if (cen && crd == idx && mt[idx] == cpos) return {cres, 4'h0};
    return {mv[idx], mt[idx]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      mv[i] = 32'h0;
      mt[i] = 4'h0;
    end
  endtask

  task automatic model_update();
    logic [3:0] nt [32];
    if (!rst_n) begin
      model_clear();
      return;
    end
    if (!rdy) return;
    nt = mt;
    if (cen && crd != 5'd0) begin
      mv[crd] = cres;
      if (mt[crd] == cpos) nt[crd] = 4'h0;
    end
    if (flush) begin
      for (int i = 0; i < 32; i++) nt[i] = 4'h0;
    end else if (ien && ird != 5'd0) begin
      nt[ird] = ipos;
    end
    mt = nt;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    rdy = 1'b1; ien = 1'b0; cen = 1'b0; flush = 1'b0;
    ird = 5'd0; ipos = 4'd0; crd = 5'd0; cpos = 4'd0;
    cres = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    model_clear();
    rs1 = 5'd5; rs2 = 5'd0;
    #1;
    total++;
    if ({rs1_val, rs1_tag} !== 36'h0) begin
      bad++;
      $display("FAIL reset_rs1 got %h/%0d want 0/0", rs1_val, rs1_tag);
    end
    total++;
    if ({rs2_val, rs2_tag} !== 36'h0) begin
      bad++;
      $display("FAIL reset_rs2 got %h/%0d want 0/0", rs2_val, rs2_tag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_issue_commit();
    ien = 1'b1; ird = 5'd5; ipos = 4'd3;
    step();
    idle();
    rs1 = 5'd5;
    #1;
    total++;
    if ({rs1_val, rs1_tag} !== {32'h0, 4'd3}) begin
      bad++;
      $display("FAIL issue_tag got %h/%0d want 0/3", rs1_val, rs1_tag);
    end
    cen = 1'b1; crd = 5'd5; cpos = 4'd3; cres = 32'hDEADBEEF;
    #1;
    total++;
    if ({rs1_val, rs1_tag} !== {32'hDEADBEEF, 4'd0}) begin
      bad++;
      $display("FAIL bypass got %h/%0d want deadbeef/0", rs1_val, rs1_tag);
    end
    step();
    idle();
    #1;
    total++;
    if ({rs1_val, rs1_tag} !== {32'hDEADBEEF, 4'd0}) begin
      bad++;
      $display("FAIL commit_store got %h/%0d want deadbeef/0", rs1_val, rs1_tag);
    end
  endtask

  task automatic test_younger_rename();
    ien = 1'b1; ird = 5'd7; ipos = 4'd2;
    step();
    ipos = 4'd4;
    step();
    idle();
    cen = 1'b1; crd = 5'd7; cpos = 4'd2; cres = 32'h11;
    rs1 = 5'd7;
    #1;
    total++;
    if ({rs1_val, rs1_tag} !== {32'h0, 4'd4}) begin
      bad++;
      $display("FAIL stale_no_bypass got %h/%0d want 0/4", rs1_val, rs1_tag);
    end
    step();
    idle();
    #1;
    total++;
    if ({rs1_val, rs1_tag} !== {32'h11, 4'd4}) begin
      bad++;
      $display("FAIL younger_survives got %h/%0d want 11/4", rs1_val, rs1_tag);
    end
  endtask

  task automatic test_same_cycle();
    ien = 1'b1; ird = 5'd9; ipos = 4'd5;
    step();
    ipos = 4'd6;
    cen = 1'b1; crd = 5'd9; cpos = 4'd5; cres = 32'h22;
    step();
    idle();
    rs2 = 5'd9;
    #1;
    total++;
    if ({rs2_val, rs2_tag} !== {32'h22, 4'd6}) begin
      bad++;
      $display("FAIL issue_wins got %h/%0d want 22/6", rs2_val, rs2_tag);
    end
  endtask

  task automatic test_flush();
    ien = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      ird = 5'(r); ipos = 4'(r);
      step();
    end
    flush = 1'b1;
    cen = 1'b1; crd = 5'd1; cpos = 4'd1; cres = 32'h80;
    ird = 5'd4; ipos = 4'd7;
    step();
    idle();
    rs1 = 5'd1; rs2 = 5'd2;
    #1;
    total++;
    if ({rs1_val, rs1_tag} !== {32'h80, 4'd0}) begin
      bad++;
      $display("FAIL flush_x1 got %h/%0d want 80/0", rs1_val, rs1_tag);
    end
    total++;
    if (rs2_tag !== 4'd0) begin
      bad++;
      $display("FAIL flush_x2 got tag %0d want 0", rs2_tag);
    end
    rs1 = 5'd3; rs2 = 5'd4;
    #1;
    total++;
    if (rs1_tag !== 4'd0) begin
      bad++;
      $display("FAIL flush_x3 got tag %0d want 0", rs1_tag);
    end
    total++;
    if (rs2_tag !== 4'd0) begin
      bad++;
      $display("FAIL flush_issue_drop got tag %0d want 0", rs2_tag);
    end
    rs1 = 5'd7;
    #1;
    total++;
    if ({rs1_val, rs1_tag} !== {32'h11, 4'd0}) begin
      bad++;
      $display("FAIL flush_x7 got %h/%0d want 11/0", rs1_val, rs1_tag);
    end
  endtask

  task automatic test_rdy_hold();
    rdy = 1'b0;
    ien = 1'b1; ird = 5'd5; ipos = 4'd9;
    cen = 1'b1; crd = 5'd9; cpos = 4'd6; cres = 32'h55;
    step();
    step();
    idle();
    rs1 = 5'd5; rs2 = 5'd9;
    #1;
    total++;
    if ({rs1_val, rs1_tag} !== {32'hDEADBEEF, 4'd0}) begin
      bad++;
      $display("FAIL rdy_hold_x5 got %h/%0d want deadbeef/0", rs1_val, rs1_tag);
    end
    total++;
    if ({rs2_val, rs2_tag} !== {32'h22, 4'd0}) begin
      bad++;
      $display("FAIL rdy_hold_x9 got %h/%0d want 22/0", rs2_val, rs2_tag);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rdy   = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 19) == 0);
      ien   = $urandom_range(0, 1) == 1;
      ird   = 5'($urandom_range(0, 31));
      ipos  = 4'($urandom_range(1, 15));
      cen   = $urandom_range(0, 1) == 1;
      crd   = 5'($urandom_range(0, 31));
      cpos  = ($urandom_range(0, 1) == 1) ? mt[crd] : 4'($urandom_range(0, 15));
      cres  = $urandom;
      rs1   = ($urandom_range(0, 2) == 0) ? crd : 5'($urandom_range(0, 31));
      rs2   = 5'($urandom_range(0, 31));
      #1;
      total++;
      if ({rs1_val, rs1_tag} !== exp_rd(rs1)) begin
        bad++;
        $display("FAIL rand_rs1 n=%0d x%0d got %h want %h", n, rs1,
                 {rs1_val, rs1_tag}, exp_rd(rs1));
      end
      total++;
      if ({rs2_val, rs2_tag} !== exp_rd(rs2)) begin
        bad++;
        $display("FAIL rand_rs2 n=%0d x%0d got %h want %h", n, rs2,
                 {rs2_val, rs2_tag}, exp_rd(rs2));
      end
      step();
    end
    idle();
    for (int r = 0; r < 32; r++) begin
      rs1 = 5'(r);
      #1;
      total++;
      if ({rs1_val, rs1_tag} !== exp_rd(rs1)) begin
        bad++;
        $display("FAIL sweep x%0d got %h want %h", r, {rs1_val, rs1_tag}, exp_rd(rs1));
      end
    end
  endtask

  task automatic test_async_reset();
    idle();
    ien = 1'b1; ird = 5'd12; ipos = 4'd8;
    cen = 1'b1; crd = 5'd12; cpos = 4'd0; cres = 32'hA5A5A5A5;
    step();
    idle();
    rs1 = 5'd12; rs2 = 5'd12;
    #1;
    total++;
    if ({rs1_val, rs1_tag} !== {32'hA5A5A5A5, 4'd8}) begin
      bad++;
      $display("FAIL pre_reset_x12 got %h/%0d want a5a5a5a5/8", rs1_val, rs1_tag);
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({rs2_val, rs2_tag} !== 36'h0) begin
      bad++;
      $display("FAIL async_reset got %h/%0d want 0/0", rs2_val, rs2_tag);
    end
    #1;
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    flush = 1'b1;
    cen = 1'b1; crd = 5'd3; cpos = 4'd0; cres = 32'hAA;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle();
    rs1 = 5'd3;
    #1;
    total++;
    if ({rs1_val, rs1_tag} !== 36'h0) begin
      bad++;
      $display("FAIL reset_dominates got %h/%0d want 0/0", rs1_val, rs1_tag);
    end
  endtask

  initial begin
    test_reset();
    test_issue_commit();
    test_younger_rename();
    test_same_cycle();
    test_flush();
    test_rdy_hold();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
